gpio_in_cond: RTL and testbench
===============================

# gpio_in_cond

Input conditioning stage placed between the GPIO pads and the Wishbone GPIO register block. For each bit it synchronises the asynchronous pad input, debounces it with a programmable stability window and produces a clean level for the GPIO block's `gpio_i` bus. It also produces single-cycle rise/fall pulses and sticky per-bit edge-pending flags for the interrupt logic.

## Interface
Parameters:
- `WIDTH`, default 8: number of GPIO bits.
- `DEB_CYCLES`, default 27000: stability window in clocks (1 ms at 27 MHz).
  - Legal range: 1 to 2^20.
  - The per-bit counter width is `$clog2(DEB_CYCLES+1)`.

Ports:
- `i_clk`  in  1: system clock.
- `i_reset_n`  in  1: reset, asynchronous, active-low.
- `i_pad`  in  WIDTH: raw pad inputs, asynchronous to `i_clk`.
- `i_bypass`  in  1: 1 = skip debounce; the stable level follows the synchroniser output.
- `i_clr`  in  WIDTH: per-bit write-1-to-clear for `o_pending`, sampled each clock.
- `o_gpio`  out  WIDTH: debounced level; connects to the GPIO block's `gpio_i`.
- `o_rise`  out  WIDTH: one-cycle pulse when the `o_gpio` bit goes 0→1.
- `o_fall`  out  WIDTH: one-cycle pulse when the `o_gpio` bit goes 1→0.
- `o_pending`  out  WIDTH: sticky flag, set by any `o_rise` or `o_fall` on that bit.
- `o_irq`  out  1: OR-reduction of `o_pending`, registered.

## Operation
- **Synchroniser.** Two flops per bit: `s1 <= i_pad`, `s2 <= s1`. Only `s2` is used downstream.
- **Per-bit debounce.** Each bit has a stable register `st` (drives `o_gpio`) and a counter `cnt`.
  - `s2 == st`: `cnt <= 0`.
  - `s2 != st` and `cnt < DEB_CYCLES-1`: `cnt <= cnt+1`.
  - `s2 != st` and `cnt == DEB_CYCLES-1`: `st <= s2`, `cnt <= 0`.
  - Any return of `s2` to `st` before the window expires clears `cnt`. The glitch is rejected.
- **Bypass.** While `i_bypass=1`: `st <= s2` every clock and `cnt` is held at 0. Deasserting bypass takes effect on the next clock with `cnt=0`.
- **Edges.**
  - `o_rise <= ~st & st_next`, `o_fall <= st & ~st_next`.
  - Registered in the same clock as the `st` update, so each pulse lasts exactly one cycle.
- **Pending.** `o_pending[i] <= (o_pending[i] & ~i_clr[i]) | rise_next[i] | fall_next[i]`.
  - When set and clear coincide on the same bit, set wins.
- **IRQ.** `o_irq <= |pending_next`.
- **Reset values.** All flops, including `s1`, `s2`, `st` and `cnt`, reset to 0. So every output resets to 0: `o_gpio`, `o_rise`, `o_fall`, `o_pending` and `o_irq`.
  - A pad held high through reset release therefore produces a normal rise pulse and pending flag after the full latency.
- **Reset mid-window.** Asserting reset clears the counters immediately. After release, debouncing restarts from zero with no partial credit.
- **Independence.** Bits are fully independent. Simultaneous changes on several bits each follow their own counter.

## Timing
- Pad change sampled at rising edge 1 (into `s1`).
  - Debounced: `o_gpio` and the `o_rise`/`o_fall` pulse update at edge `DEB_CYCLES+2`, provided the pad stays constant throughout.
  - Bypass: they update at edge 3.
  - `DEB_CYCLES=1` gives the same timing as bypass.
- `o_pending` updates at the same edge as the pulse.
- `o_irq` updates at the same edge as `o_pending`, because it is computed from `pending_next`.
- `i_clr` takes effect at the next edge: `o_pending` and `o_irq` fall one cycle after `i_clr` is sampled high, unless a new edge on that bit occurs in the same cycle.
- The counter never wraps: its maximum held value is `DEB_CYCLES-1`.

## Test plan
- **Reset values:** reset with `i_pad=8'h00` → all outputs 0.
  - Then `i_pad=8'h01` with `DEB_CYCLES=4` → `o_gpio=8'h01` and `o_rise=8'h01` for one cycle at edge 6; `o_pending=8'h01` and `o_irq=1` at edge 6.
- **Glitch rejection:** `DEB_CYCLES=4`, bit 3 pulsed high for 3 clocks then low → `o_gpio`, `o_rise` and `o_pending` all stay 0. A 4-clock pulse → rise at edge 6, then fall 4+ cycles later.
- **Bypass:** `i_bypass=1`, `i_pad` 8'h00→8'hA5 → `o_gpio=8'hA5` at edge 3, `o_rise=8'hA5` for one cycle.
- **Clear vs set:** `o_pending=8'h01`.
  - Pulse `i_clr=8'h01` → 8'h00 next cycle, `o_irq` 0.
  - Repeat with a bit-0 fall edge in the same cycle as `i_clr` → `o_pending` stays 8'h01.
- **Reset mid-window:** `DEB_CYCLES=8`, pad high for 5 clocks, then async reset pulse (not clock-aligned) → outputs 0 immediately. After release, the pad still high → rise at edge 10 after release.
- **Independent bits:** bits 0 and 7 change 2 clocks apart → pulses are 2 clocks apart; `o_pending=8'h81`.

Source files
------------

// File: rtl/gpio_in_cond.sv
// gpio_in_cond: per-bit pad synchroniser, debounce filter, edge pulses,
// sticky edge-pending flags and a registered interrupt request.
module gpio_in_cond #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEB_CYCLES = 27000
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_pad,
  input  logic             i_bypass,
  input  logic [WIDTH-1:0] i_clr,
  output logic [WIDTH-1:0] o_gpio,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic [WIDTH-1:0] o_pending,
  output logic             o_irq
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_st;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] r_pend;
  logic             r_irq;

  logic [WIDTH-1:0] w_st_next;
  logic [CW-1:0]    w_cnt_next [WIDTH];
  logic [WIDTH-1:0] w_rise_next;
  logic [WIDTH-1:0] w_fall_next;
  logic [WIDTH-1:0] w_pend_next;

  // Debounce decision per bit: a differing level must persist for the whole
  // window; any return to the stable level restarts the count from zero.
  always_comb begin
    w_st_next = r_st;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_cnt_next[i] = '0;
      if (i_bypass) begin
        w_st_next[i] = r_s2[i];
      end else if (r_s2[i] != r_st[i]) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_st_next[i] = r_s2[i];
        end else begin
          w_cnt_next[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Edge detection and pending update; a new edge wins over a coincident clear.
  always_comb begin
    w_rise_next = ~r_st & w_st_next;
    w_fall_next = r_st & ~w_st_next;
    w_pend_next = (r_pend & ~i_clr) | w_rise_next | w_fall_next;
  end

  // Two-flop synchroniser for the asynchronous pad inputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_pad;
      r_s2 <= r_s1;
    end
  end

  // Stable level, window counters, pulses, pending flags and irq.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_st   <= '0;
      r_rise <= '0;
      r_fall <= '0;
      r_pend <= '0;
      r_irq  <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_st   <= w_st_next;
      r_rise <= w_rise_next;
      r_fall <= w_fall_next;
      r_pend <= w_pend_next;
      r_irq  <= |w_pend_next;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
    end
  end

  assign o_gpio    = r_st;
  assign o_rise    = r_rise;
  assign o_fall    = r_fall;
  assign o_pending = r_pend;
  assign o_irq     = r_irq;

endmodule

// File: tb/tb_gpio_in_cond.sv
// tb_gpio_in_cond: directed checks of gpio_in_cond with 4- and 8-cycle windows.
module tb_gpio_in_cond;

  logic       clk = 1'b0;
  logic       rst4_n, rst8_n;
  logic [7:0] pad4, pad8, clr4, clr8;
  logic       byp4, byp8;
  logic [7:0] gpio4, rise4, fall4, pend4;
  logic [7:0] gpio8, rise8, fall8, pend8;
  logic       irq4, irq8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gpio_in_cond #(.WIDTH(8), .DEB_CYCLES(4)) dut4 (
    .i_clk(clk), .i_reset_n(rst4_n), .i_pad(pad4), .i_bypass(byp4),
    .i_clr(clr4), .o_gpio(gpio4), .o_rise(rise4), .o_fall(fall4),
    .o_pending(pend4), .o_irq(irq4)
  );

  gpio_in_cond #(.WIDTH(8), .DEB_CYCLES(8)) dut8 (
    .i_clk(clk), .i_reset_n(rst8_n), .i_pad(pad8), .i_bypass(byp8),
    .i_clr(clr8), .o_gpio(gpio8), .o_rise(rise8), .o_fall(fall8),
    .o_pending(pend8), .o_irq(irq8)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk4(input string tag, input logic [7:0] g, input logic [7:0] r,
                      input logic [7:0] f, input logic [7:0] p, input logic q);
    chk({tag, ".gpio"}, gpio4, g);
    chk({tag, ".rise"}, rise4, r);
    chk({tag, ".fall"}, fall4, f);
    chk({tag, ".pend"}, pend4, p);
    chk({tag, ".irq"}, {7'd0, irq4}, {7'd0, q});
  endtask

  task automatic chk8(input string tag, input logic [7:0] g, input logic [7:0] r,
                      input logic [7:0] f, input logic [7:0] p, input logic q);
    chk({tag, ".gpio"}, gpio8, g);
    chk({tag, ".rise"}, rise8, r);
    chk({tag, ".fall"}, fall8, f);
    chk({tag, ".pend"}, pend8, p);
    chk({tag, ".irq"}, {7'd0, irq8}, {7'd0, q});
  endtask

  initial begin
    rst4_n = 1'b0; rst8_n = 1'b0;
    pad4 = '0; pad8 = '0; clr4 = '0; clr8 = '0;
    byp4 = 1'b0; byp8 = 1'b0;
    tick(3);
    chk4("reset4", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    chk8("reset8", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    rst4_n = 1'b1; rst8_n = 1'b1;
    tick(2);

    // Bit 0 rises: update at edge 6
    pad4 = 8'h01;
    tick(5);
    chk4("rise_e5", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tick(1);
    chk4("rise_e6", 8'h01, 8'h01, 8'h00, 8'h01, 1'b1);
    tick(1);
    chk4("rise_e7", 8'h01, 8'h00, 8'h00, 8'h01, 1'b1);

    // Clear coinciding with a bit-0 fall edge: set wins
    pad4 = 8'h00;
    tick(5);
    chk4("fall_e5", 8'h01, 8'h00, 8'h00, 8'h01, 1'b1);
    clr4 = 8'h01;
    tick(1);
    clr4 = 8'h00;
    chk4("setwins", 8'h00, 8'h00, 8'h01, 8'h01, 1'b1);

    // Plain clear
    clr4 = 8'h01;
    tick(1);
    clr4 = 8'h00;
    chk4("clear", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

    // Glitch of 3 clocks on bit 3 is rejected
    pad4 = 8'h08;
    tick(3);
    pad4 = 8'h00;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk4("glitch", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    end

    // 4-clock pulse on bit 3 passes: rise at edge 6, fall at edge 10
    pad4 = 8'h08;
    tick(4);
    pad4 = 8'h00;
    tick(1);
    chk4("p4_e5", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tick(1);
    chk4("p4_e6", 8'h08, 8'h08, 8'h00, 8'h08, 1'b1);
    tick(3);
    chk4("p4_e9", 8'h08, 8'h00, 8'h00, 8'h08, 1'b1);
    tick(1);
    chk4("p4_e10", 8'h00, 8'h00, 8'h08, 8'h08, 1'b1);
    clr4 = 8'hFF;
    tick(1);
    clr4 = 8'h00;
    chk4("p4_clr", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

    // Bypass: update at edge 3
    byp4 = 1'b1;
    pad4 = 8'hA5;
    tick(2);
    chk4("byp_e2", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tick(1);
    chk4("byp_e3", 8'hA5, 8'hA5, 8'h00, 8'hA5, 1'b1);
    tick(1);
    chk4("byp_e4", 8'hA5, 8'h00, 8'h00, 8'hA5, 1'b1);
    pad4 = 8'h00;
    tick(3);
    chk4("bypf_e3", 8'h00, 8'h00, 8'hA5, 8'hA5, 1'b1);
    byp4 = 1'b0;
    clr4 = 8'hFF;
    tick(1);
    clr4 = 8'h00;
    chk4("byp_clr", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

    // Independent bits: bit 0 then bit 7 two clocks later
    pad4 = 8'h01;
    tick(2);
    pad4 = 8'h81;
    tick(4);
    chk4("ind_e6", 8'h01, 8'h01, 8'h00, 8'h01, 1'b1);
    tick(1);
    chk4("ind_e7", 8'h01, 8'h00, 8'h00, 8'h01, 1'b1);
    tick(1);
    chk4("ind_e8", 8'h81, 8'h80, 8'h00, 8'h81, 1'b1);

    // Reset mid-window on the 8-cycle instance
    pad8 = 8'h01;
    tick(5);
    chk8("mid_e5", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    #3 rst8_n = 1'b0;
    #1 chk8("mid_rst", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    #1 rst8_n = 1'b1;
    tick(9);
    chk8("mid_e9", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tick(1);
    chk8("mid_e10", 8'h01, 8'h01, 8'h00, 8'h01, 1'b1);
    tick(1);
    chk8("mid_e11", 8'h01, 8'h00, 8'h00, 8'h01, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
